// File: rtl/afifo_read_drain.sv
// rtl/afifo_read_drain.sv - read-side drain of the async FIFO: pop control, 2-entry skid buffer, pattern checker
module afifo_read_drain #(
   parameter int DataSize = 3,
   parameter int CntWidth = 16
) (
   input  logic                Rclk,
   input  logic                Rresetn,
   input  logic                empty,
   output logic                Pop,
   input  logic [DataSize-1:0] DataOut,
   output logic                m_valid,
   output logic [DataSize-1:0] m_data,
   input  logic                m_ready,
   input  logic                chk_en,
   output logic [CntWidth-1:0] word_cnt,
   output logic [CntWidth-1:0] err_cnt,
   output logic                err_flag
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t                occ_q, occ_d;
   logic                inflight_q, inflight_d;
   logic [DataSize-1:0] head_q, head_d;
   logic [DataSize-1:0] tail_q, tail_d;
   logic [DataSize-1:0] expected_q, expected_d;
   logic [CntWidth-1:0] word_cnt_q, word_cnt_d;
   logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
   logic                err_flag_q, err_flag_d;

   logic                xfer;
   logic                cap;
   logic [2:0]          load;

   // The word popped last cycle lands on DataOut now; count it against the
   // space that will remain after any transfer this cycle. m_ready feeds Pop
   // combinationally so a draining buffer keeps popping every cycle.
   assign xfer       = (occ_q != EMPTY) && m_ready;
   assign cap        = inflight_q;
   assign load       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
   assign Pop        = Rresetn && !empty && (load < 3'd2);
   assign inflight_d = Pop;

   assign m_valid  = (occ_q != EMPTY);
   assign m_data   = head_q;
   assign word_cnt = word_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign err_flag = err_flag_q;

   // Occupancy FSM and skid buffer: head is always the oldest word
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         EMPTY: begin
            if (cap) begin
               head_d = DataOut;
               occ_d  = ONE;
            end
         end
         ONE: begin
            if (cap && xfer) begin
               head_d = DataOut;
            end else if (cap) begin
               tail_d = DataOut;
               occ_d  = TWO;
            end else if (xfer) begin
               occ_d = EMPTY;
            end
         end
         TWO: begin
            // Capture without transfer cannot happen here; the pop rule forbids it
            if (xfer) begin
               head_d = tail_q;
               if (cap) begin
                  tail_d = DataOut;
               end else begin
                  occ_d = ONE;
               end
            end
         end
         default: occ_d = EMPTY;
      endcase
   end

   // Capture counter and incrementing-pattern checker; expected always
   // follows the last captured word so one bad word costs one error
   always_comb begin
      expected_d = expected_q;
      word_cnt_d = word_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      if (cap) begin
         expected_d = DataOut + DataSize'(1);
         if (!(&word_cnt_q)) begin
            word_cnt_d = word_cnt_q + CntWidth'(1);
         end
         if (chk_en && (DataOut != expected_q)) begin
            err_flag_d = 1'b1;
            if (!(&err_cnt_q)) begin
               err_cnt_d = err_cnt_q + CntWidth'(1);
            end
         end
      end
   end

   // State registers; reset discards buffered and in-flight words
   always_ff @(posedge Rclk or negedge Rresetn) begin
      if (!Rresetn) begin
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         expected_q <= '0;
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         expected_q <= expected_d;
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
      end
   end

endmodule

// File: tb/tb_afifo_read_drain.sv
// tb/tb_afifo_read_drain.sv - directed self-checking bench for afifo_read_drain
module tb_afifo_read_drain;

   logic        Rclk;
   logic        Rresetn;
   logic        empty;
   logic        Pop;
   logic [2:0]  DataOut;
   logic        m_valid;
   logic [2:0]  m_data;
   logic        m_ready;
   logic        chk_en;
   logic [15:0] word_cnt;
   logic [15:0] err_cnt;
   logic        err_flag;

   afifo_read_drain #(.DataSize(3), .CntWidth(16)) dut (
      .Rclk     (Rclk),
      .Rresetn  (Rresetn),
      .empty    (empty),
      .Pop      (Pop),
      .DataOut  (DataOut),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready),
      .chk_en   (chk_en),
      .word_cnt (word_cnt),
      .err_cnt  (err_cnt),
      .err_flag (err_flag)
   );

   initial Rclk = 1'b0;
   always #5 Rclk = ~Rclk;

   int passed = 0;
   int total  = 0;
   int cyc_n  = 0;
   int occ_b  = 0;
   int pe_viol = 0;
   int occ_viol = 0;
   int mv_viol = 0;
   int hold_viol = 0;
   logic inflight_b = 1'b0;
   logic hold_pend = 1'b0;
   logic [2:0] hold_data = 3'd0;
   logic tog = 1'b0;
   logic tog_en = 1'b0;
   logic pop_s, mv_s, xfer_s;
   logic [2:0] md_s;
   int fifo_q[$];
   int ref_q[$];
   int out_d[$];
   int out_c[$];
   int pop_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input int got[$], input int want[$]);
      int bad;
      bad = 0;
      chk({tag, "_len"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++) begin
         if (got[i] != want[i]) bad++;
      end
      chk({tag, "_order"}, bad, 0);
   endtask

   task automatic upd_empty();
      empty = (fifo_q.size() == 0) || (tog_en && tog);
   endtask

   task automatic load(input int w);
      fifo_q.push_back(w);
      ref_q.push_back(w);
      upd_empty();
   endtask

   task automatic clear_logs();
      out_d.delete();
      out_c.delete();
      pop_cyc.delete();
      ref_q.delete();
   endtask

   // One Rclk cycle: sample at negedge, FIFO model responds just after posedge
   task automatic cyc();
      @(negedge Rclk);
      pop_s  = Pop;
      mv_s   = m_valid;
      md_s   = m_data;
      xfer_s = m_valid && m_ready;
      if (Pop && empty) pe_viol++;
      if (mv_s !== (occ_b != 0)) mv_viol++;
      if (hold_pend && (!mv_s || md_s !== hold_data)) hold_viol++;
      hold_pend = mv_s && !m_ready;
      hold_data = md_s;
      if (pop_s) pop_cyc.push_back(cyc_n);
      if (xfer_s) begin
         out_d.push_back(int'(md_s));
         out_c.push_back(cyc_n);
      end
      @(posedge Rclk);
      #1;
      occ_b = occ_b + (inflight_b ? 1 : 0) - (xfer_s ? 1 : 0);
      if (occ_b > 2 || occ_b < 0) occ_viol++;
      inflight_b = pop_s;
      if (pop_s && fifo_q.size() > 0) DataOut = 3'(fifo_q.pop_front());
      cyc_n++;
      if (tog_en) tog = !tog;
      upd_empty();
   endtask

   task automatic apply_reset(input int n);
      Rresetn = 1'b0;
      fifo_q.delete();
      occ_b = 0;
      inflight_b = 1'b0;
      hold_pend = 1'b0;
      upd_empty();
      repeat (n) cyc();
      Rresetn = 1'b1;
   endtask

   initial begin
      Rresetn = 1'b0;
      empty   = 1'b0;
      DataOut = 3'd0;
      m_ready = 1'b1;
      chk_en  = 1'b1;
      #1;
      // 1: reset holds everything quiet, Pop forced low even with empty=0
      chk("t1_pop_forced_in_reset", Pop, 0);
      repeat (10) cyc();
      chk("t1_pop_reset", pop_s, 0);
      chk("t1_mvalid_reset", mv_s, 0);
      chk("t1_mdata_reset", md_s, 0);
      chk("t1_word_cnt_reset", word_cnt, 0);
      chk("t1_err_cnt_reset", err_cnt, 0);
      chk("t1_err_flag_reset", err_flag, 0);
      Rresetn = 1'b1;
      repeat (10) cyc();
      chk("t1_pop_empty", pop_s, 0);
      chk("t1_mvalid_empty", mv_s, 0);
      chk("t1_word_cnt_idle", word_cnt, 0);

      // 2: 0..7 at full throughput
      clear_logs();
      for (int i = 0; i < 8; i++) load(i);
      repeat (14) cyc();
      chk("t2_pop_count", pop_cyc.size(), 8);
      chk("t2_pop_span", (pop_cyc.size() >= 8) ? pop_cyc[7] - pop_cyc[0] : -1, 7);
      chk("t2_latency", (out_c.size() > 0 && pop_cyc.size() > 0) ? out_c[0] - pop_cyc[0] : -1, 2);
      chk_seq("t2_data", out_d, ref_q);
      chk("t2_out_span", (out_c.size() >= 8) ? out_c[7] - out_c[0] : -1, 7);
      chk("t2_word_cnt", word_cnt, 8);
      chk("t2_err_cnt", err_cnt, 0);
      chk("t2_err_flag", err_flag, 0);

      // 3: backpressure stops after two pops, then drains in order
      clear_logs();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) load(i);
      repeat (6) cyc();
      chk("t3_pop_count_blocked", pop_cyc.size(), 2);
      chk("t3_pop_low", pop_s, 0);
      chk("t3_mvalid_held", mv_s, 1);
      chk("t3_mdata_held", md_s, 0);
      m_ready = 1'b1;
      repeat (14) cyc();
      chk_seq("t3_data", out_d, ref_q);
      chk("t3_out_span", (out_c.size() >= 8) ? out_c[7] - out_c[0] : -1, 7);
      chk("t3_pop_count", pop_cyc.size(), 8);
      chk("t3_word_cnt", word_cnt, 16);
      chk("t3_err_cnt", err_cnt, 0);

      // 4: one bad word counts once, checker resyncs
      clear_logs();
      load(0); load(1); load(2); load(5); load(6);
      repeat (10) cyc();
      chk("t4_err_cnt", err_cnt, 1);
      chk("t4_err_flag", err_flag, 1);
      chk("t4_word_cnt", word_cnt, 21);
      apply_reset(2);
      clear_logs();
      chk_en = 1'b0;
      load(0); load(1); load(2); load(5); load(6);
      repeat (10) cyc();
      chk("t4_err_cnt_nochk", err_cnt, 0);
      chk("t4_err_flag_nochk", err_flag, 0);
      chk("t4_word_cnt_nochk", word_cnt, 5);

      // 5: asynchronous reset with a full buffer and a pop being issued
      clear_logs();
      chk_en  = 1'b1;
      m_ready = 1'b0;
      load(3); load(4);
      repeat (3) cyc();
      load(5); load(6); load(7);
      chk("t5_err_cnt_pre", err_cnt, 1);
      chk("t5_err_flag_pre", err_flag, 1);
      chk("t5_word_cnt_pre", word_cnt, 7);
      @(negedge Rclk);
      m_ready = 1'b1;
      #1;
      chk("t5_pop_before_reset", Pop, 1);
      #1;
      Rresetn = 1'b0;
      #1;
      chk("t5_pop_reset", Pop, 0);
      chk("t5_mvalid_reset", m_valid, 0);
      chk("t5_mdata_reset", m_data, 0);
      chk("t5_word_cnt_reset", word_cnt, 0);
      chk("t5_err_cnt_reset", err_cnt, 0);
      chk("t5_err_flag_reset", err_flag, 0);
      apply_reset(2);
      clear_logs();
      load(0); load(1);
      repeat (8) cyc();
      chk_seq("t5_data", out_d, ref_q);
      chk("t5_err_cnt_post", err_cnt, 0);
      chk("t5_err_flag_post", err_flag, 0);
      chk("t5_word_cnt_post", word_cnt, 2);

      // 6: empty toggling with random backpressure
      clear_logs();
      chk_en = 1'b0;
      tog_en = 1'b1;
      tog    = 1'b0;
      for (int i = 0; i < 20; i++) load(int'($urandom_range(0, 7)));
      for (int i = 0; i < 400 && out_d.size() < 20; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      tog_en = 1'b0;
      m_ready = 1'b1;
      chk_seq("t6_data", out_d, ref_q);
      chk("t6_pop_count", pop_cyc.size(), 20);

      // Properties watched on every cycle of the run
      chk("pop_while_empty", pe_viol, 0);
      chk("occupancy_bound", occ_viol, 0);
      chk("mvalid_vs_occupancy", mv_viol, 0);
      chk("mdata_hold_under_backpressure", hold_viol, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
